alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, for example a fetch/branch unit and the execute stage.
- Each requester issues an operation (a, b, kontrol) with a valid/ready handshake. The block grants round-robin, drives the ALU from registered operands, captures c/z_flag, and returns the result on one response channel tagged with the requester id.
- Rejects kontrol codes the ALU does not define, so the ALU's undefined-code hold behaviour is never reached.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU (32).
- KW, 4, kontrol code width.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand a (shift amount for SLL/SRL/SRA = a[4:0])
- req0_b  in  WIDTH  operand b
- req0_kontrol  in  KW  op code
- req1_valid, req1_ready, req1_a, req1_b, req1_kontrol  same as requester 0
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_kontrol  out  KW  to ALU kontrol
- alu_c  in  WIDTH  from ALU c
- alu_z_flag  in  1  from ALU z_flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester the result belongs to
- rsp_c  out  WIDTH  result
- rsp_z  out  1  zero flag
- rsp_err  out  1  illegal kontrol code

Behaviour:
- Legal kontrol codes:
  - 0000 ADD
  - 0100 SUB
  - 0001 AND
  - 0101 OR
  - 0010 XOR
  - 0110 LUI
  - 0011 SLL
  - 0111 SRL
  - 1111 SRA
  - Every other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- Reset (async assert, sync release):
  - state = IDLE, priority pointer = req0 preferred.
  - Operand regs, alu_a/alu_b = 0; alu_kontrol = 0000.
  - rsp_valid = 0; rsp_id/rsp_c/rsp_z/rsp_err = 0.
  - reqN_ready = 0.
- IDLE:
  - grant = the valid requester; if both are valid, the one named by the priority pointer.
  - reqN_ready = 1 combinationally, only for the granted requester and only in IDLE.
  - On the handshake edge: capture a, b, kontrol and id into registers, then go to EXEC. If kontrol is illegal, go directly to RESP with rsp_err = 1, rsp_c = 0, rsp_z = 0.
- EXEC:
  - alu_a/alu_b/alu_kontrol are driven only from the registered operands and stay stable for the whole state.
  - At the end of the cycle: rsp_c <= alu_c, rsp_z <= alu_z_flag, rsp_err <= 0; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_* are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE and set the priority pointer to the non-served requester.
- Latency and throughput:
  - Legal op: accept at edge T, rsp_valid high from T+2 (EXEC cycle T+1).
  - Illegal op: rsp_valid high from T+1.
  - Maximum rate is one op per 3 cycles; the ALU is not pipelined and only one transaction is in flight.
- Fairness: under continuous contention grants alternate 0,1,0,1. A lone requester is granted every time regardless of the pointer.
- Requester rule: a, b, kontrol must be held while valid && !ready. The arbiter samples only at the handshake.
- No request is accepted while in EXEC or RESP; ready stays 0 for both requesters.
- Reset mid-operation: the transaction is dropped silently with no response and nothing is replayed.
- alu_* outputs keep their last values in IDLE and RESP; no glitching is required.

Decomposition:
- Shared package alu_pkg:
  - kontrol code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA
  - function kontrol_legal()
  - FSM state encoding type
- Optional sub-module rr_grant2: a 2-input round-robin grant with pointer update on completion. The ALU itself is instantiated outside this block.

Test Plan:
- Single ADD: req0 a=5, b=7, kontrol=0000 -> req0_ready at T; rsp_valid at T+2 with rsp_id=0, rsp_c=12, rsp_z=0, rsp_err=0.
- SUB to zero: req1 a=b=0x1234, kontrol=0100 -> rsp_id=1, rsp_c=0, rsp_z=1.
- Contention: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1 with ops accepted every 3 cycles. An SRA with b=0x80000000 and a=4 returns 0xF8000000.
- Illegal code: req0 kontrol=1000 -> rsp at T+1 with rsp_err=1, rsp_c=0. The ALU inputs are unchanged from the previous op.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, both ready=0, req1 waits; after rsp_ready=1, req1 is granted next.
- Reset mid-EXEC: rst_n low during EXEC -> rsp_valid=0 immediately and all outputs at reset values. After release, the first grant goes to req0 when both requesters are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: kontrol codes, legality check and FSM states.
package alu_pkg;

    localparam int KW_P = 4;

    localparam logic [KW_P-1:0] ALU_ADD = 4'b0000;
    localparam logic [KW_P-1:0] ALU_SUB = 4'b0100;
    localparam logic [KW_P-1:0] ALU_AND = 4'b0001;
    localparam logic [KW_P-1:0] ALU_OR  = 4'b0101;
    localparam logic [KW_P-1:0] ALU_XOR = 4'b0010;
    localparam logic [KW_P-1:0] ALU_LUI = 4'b0110;
    localparam logic [KW_P-1:0] ALU_SLL = 4'b0011;
    localparam logic [KW_P-1:0] ALU_SRL = 4'b0111;
    localparam logic [KW_P-1:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

    function automatic logic kontrol_legal(input logic [KW_P-1:0] k);
        case (k)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant; the pointer moves to the other requester when a transaction completes.
module rr_grant2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       served_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic ptr_q;

    assign gnt_valid_o = |req_i;
    // Contention resolved by the pointer; a lone requester wins regardless.
    assign gnt_id_o    = (req_i == 2'b11) ? ptr_q : req_i[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 1'b0;
        else if (done_i)
            ptr_q <= ~served_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; one transaction in flight, tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [KW-1:0]    req0_kontrol,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [KW-1:0]    req1_kontrol,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [KW-1:0]    alu_kontrol,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_z,
    output logic             rsp_err
);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [KW-1:0]    k_q;
    logic             rsp_valid_q, rsp_id_q, rsp_z_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_c_q;

    logic             gnt_valid, gnt_id, accept, done;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [KW-1:0]    sel_k;

    rr_grant2 u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      ({req1_valid, req0_valid}),
        .done_i     (done),
        .served_i   (rsp_id_q),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    assign accept     = rst_n && (state_q == ST_IDLE) && gnt_valid;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept &&  gnt_id;
    assign done       = (state_q == ST_RESP) && rsp_ready;

    assign sel_a = gnt_id ? req1_a       : req0_a;
    assign sel_b = gnt_id ? req1_b       : req0_b;
    assign sel_k = gnt_id ? req1_kontrol : req0_kontrol;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_kontrol = k_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_c       = rsp_c_q;
    assign rsp_z       = rsp_z_q;
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_z_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    rsp_id_q <= gnt_id;
                    // Illegal codes never reach the ALU, so its inputs keep the last legal op.
                    if (kontrol_legal(sel_k)) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        k_q     <= sel_k;
                        state_q <= ST_EXEC;
                    end else begin
                        rsp_c_q     <= '0;
                        rsp_z_q     <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_EXEC: begin
                    rsp_c_q     <= alu_c;
                    rsp_z_q     <= alu_z_flag;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_kontrol, req1_kontrol;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_kontrol;
    logic        alu_z_flag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_err;
    logic [31:0] rsp_c;

    int n_pass = 0, n_total = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(32), .KW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_kontrol(req0_kontrol),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_kontrol(req1_kontrol),
        .alu_a(alu_a), .alu_b(alu_b), .alu_kontrol(alu_kontrol),
        .alu_c(alu_c), .alu_z_flag(alu_z_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    // Reference ALU: shift amount comes from a[4:0], shifted value is b; LUI passes b through.
    function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [3:0] k);
        case (k)
            4'h0:    return a + b;
            4'h4:    return a - b;
            4'h1:    return a & b;
            4'h5:    return a | b;
            4'h2:    return a ^ b;
            4'h6:    return b;
            4'h3:    return b << a[4:0];
            4'h7:    return b >> a[4:0];
            4'hF:    return $unsigned($signed(b) >>> a[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit legal_f(input logic [3:0] k);
        return k inside {4'h0, 4'h4, 4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h7, 4'hF};
    endfunction

    assign alu_c      = alu_f(alu_a, alu_b, alu_kontrol);
    assign alu_z_flag = (alu_c == 32'h0);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // Transaction-level model: busy flag, cycles until the response shows, and the pending result.
    bit          m_busy, m_ptr, m_id, m_z, m_err;
    int          m_wait;
    logic [31:0] m_c, m_alu_a, m_alu_b;
    logic [3:0]  m_alu_k;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_wait = 0;
            m_alu_a = 0; m_alu_b = 0; m_alu_k = 0;
        end else begin
            bit          g_any, g_id;
            logic [31:0] a, b;
            logic [3:0]  k;
            g_any = !m_busy && (req0_valid || req1_valid);
            g_id  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            chk("m_ready0", req0_ready, g_any && !g_id);
            chk("m_ready1", req1_ready, g_any && g_id);
            chk("m_rsp_valid", rsp_valid, m_busy && m_wait == 0);
            if (m_busy && m_wait == 0) begin
                chk("m_rsp_id", rsp_id, m_id);
                chk("m_rsp_c", rsp_c, m_c);
                chk("m_rsp_z", rsp_z, m_z);
                chk("m_rsp_err", rsp_err, m_err);
            end
            chk("m_alu_a", alu_a, m_alu_a);
            chk("m_alu_b", alu_b, m_alu_b);
            chk("m_alu_k", alu_kontrol, m_alu_k);
            if (g_any) begin
                a = g_id ? req1_a : req0_a;
                b = g_id ? req1_b : req0_b;
                k = g_id ? req1_kontrol : req0_kontrol;
                m_busy = 1; m_id = g_id;
                if (legal_f(k)) begin
                    m_alu_a = a; m_alu_b = b; m_alu_k = k;
                    m_c = alu_f(a, b, k); m_z = (m_c == 0); m_err = 0; m_wait = 1;
                end else begin
                    m_c = 0; m_z = 0; m_err = 1; m_wait = 0;
                end
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
            end else if (m_busy && rsp_ready) begin
                m_busy = 0; m_ptr = !m_id;
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic smp();  @(negedge clk);     endtask

    task automatic rnd_op(output logic [31:0] a, output logic [31:0] b, output logic [3:0] k);
        k = 4'($urandom % 16);
        a = $urandom;
        b = ($urandom % 4 == 0) ? a : $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcnt, gcyc[4];
        bit gid[4], sra_seen, a0, a1;
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_kontrol = 0;
        req1_a = 0; req1_b = 0; req1_kontrol = 0;
        tick(); smp();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_k", alu_kontrol, 0);
        chk("rst_rsp_c", rsp_c, 0);
        tick(); rst_n = 1;

        // Single ADD from req0
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_kontrol = 4'b0000;
        smp(); chk("add_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        smp(); chk("add_exec_novalid", rsp_valid, 0);
        tick(); smp();
        chk("add_valid", rsp_valid, 1); chk("add_id", rsp_id, 0);
        chk("add_c", rsp_c, 12); chk("add_z", rsp_z, 0); chk("add_err", rsp_err, 0);
        tick();

        // SUB to zero from req1
        req1_valid = 1; req1_a = 32'h1234; req1_b = 32'h1234; req1_kontrol = 4'b0100;
        smp(); chk("sub_ready", req1_ready, 1);
        tick(); req1_valid = 0;
        tick(); smp();
        chk("sub_valid", rsp_valid, 1); chk("sub_id", rsp_id, 1);
        chk("sub_c", rsp_c, 0); chk("sub_z", rsp_z, 1);
        tick();

        // Contention: alternate grants every 3 cycles
        req0_valid = 1; req0_a = 4; req0_b = 32'h8000_0000; req0_kontrol = 4'b1111;
        req1_valid = 1; req1_a = 3; req1_b = 9;             req1_kontrol = 4'b0000;
        gcnt = 0; sra_seen = 0;
        for (int i = 0; i < 30 && gcnt < 4; i++) begin
            smp();
            if (req0_ready || req1_ready) begin
                gid[gcnt] = req1_ready; gcyc[gcnt] = cyc; gcnt++;
            end
            if (rsp_valid && rsp_id == 1'b0 && !sra_seen) begin
                chk("sra_c", rsp_c, 32'hF800_0000); sra_seen = 1;
            end
            tick();
            if (gcnt == 4) begin req0_valid = 0; req1_valid = 0; end
        end
        chk("cont_grants", gcnt, 4);
        chk("cont_sra_seen", 32'(sra_seen), 1);
        if (gcnt == 4) begin
            for (int i = 0; i < 4; i++) chk("cont_order", 32'(gid[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) chk("cont_spacing", gcyc[i+1] - gcyc[i], 3);
        end
        req0_valid = 0; req1_valid = 0;
        tick(); tick();

        // Illegal code: fast error response, ALU inputs keep the last legal op (req1 ADD 3,9)
        req0_valid = 1; req0_a = 32'hDEAD; req0_b = 32'hBEEF; req0_kontrol = 4'b1000;
        smp(); chk("ill_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        smp();
        chk("ill_valid", rsp_valid, 1); chk("ill_err", rsp_err, 1);
        chk("ill_c", rsp_c, 0); chk("ill_z", rsp_z, 0);
        chk("ill_alu_a", alu_a, 3); chk("ill_alu_b", alu_b, 9); chk("ill_alu_k", alu_kontrol, 0);
        tick();

        // Backpressure: lone req0 wins despite pointer, req1 waits through a stalled response
        rsp_ready = 0;
        req0_valid = 1; req0_a = 32'hFF00_FF00; req0_b = 32'h0FF0_0FF0; req0_kontrol = 4'b0010;
        smp(); chk("bp_lone_ready", req0_ready, 1);
        tick(); req0_valid = 0;
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_kontrol = 4'b0101;
        smp(); chk("bp_exec_ready1", req1_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("bp_valid", rsp_valid, 1); chk("bp_c", rsp_c, 32'hF0F0_F0F0);
            chk("bp_id", rsp_id, 0); chk("bp_ready1", req1_ready, 0);
            tick();
        end
        rsp_ready = 1;
        smp(); chk("bp_resp_ready1", req1_ready, 0);
        tick(); smp(); chk("bp_next_ready1", req1_ready, 1);
        tick(); req1_valid = 0;
        tick(); smp(); chk("bp_or_c", rsp_c, 3); chk("bp_or_id", rsp_id, 1);
        tick();

        // Reset mid-EXEC with pointer favouring req1 beforehand
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_kontrol = 4'b0000;
        tick(); req0_valid = 0; tick(); tick();
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'hFF; req1_kontrol = 4'b0001;
        smp(); chk("rst_pre_ready1", req1_ready, 1);
        tick(); req1_valid = 0;
        rst_n = 0; #1;
        chk("mid_rsp_valid", rsp_valid, 0); chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0); chk("mid_alu_k", alu_kontrol, 0);
        chk("mid_rsp_c", rsp_c, 0); chk("mid_rsp_err", rsp_err, 0);
        req0_valid = 1; req0_a = 10; req0_b = 3; req0_kontrol = 4'b0100;
        req1_valid = 1; req1_a = 2;  req1_b = 2; req1_kontrol = 4'b0000;
        #1; chk("mid_ready0", req0_ready, 0); chk("mid_ready1", req1_ready, 0);
        tick(); tick(); rst_n = 1;
        smp(); chk("post_rst_ready0", req0_ready, 1); chk("post_rst_ready1", req1_ready, 0);

        // Randomized traffic, requester rule honoured, random backpressure
        for (int i = 0; i < 600; i++) begin
            smp(); a0 = req0_ready; a1 = req1_ready;
            tick();
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
            if (!req0_valid && $urandom % 3 == 0) begin
                rnd_op(req0_a, req0_b, req0_kontrol); req0_valid = 1;
            end
            if (!req1_valid && $urandom % 3 == 0) begin
                rnd_op(req1_a, req1_b, req1_kontrol); req1_valid = 1;
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        smp(); a0 = req0_ready; a1 = req1_ready;
        tick();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
